alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_if.sv | 43 ++++
 rtl/alu_result_stage.sv | 115 +++++++++++
 tb/tb_alu_result_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result stage and its neighbours.
// slave: the stage itself; master: upstream/downstream driver (bench or pipeline).
interface alu_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             in_valid_i;
    logic [WIDTH-1:0] in_result_i;
    logic [OPW-1:0]   in_op_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_result_o;
    logic [OPW-1:0]   out_op_o;
    logic             out_zero_o;
    logic             out_neg_o;

    modport slave (
        input  in_valid_i,
        input  in_result_i,
        input  in_op_i,
        output in_ready_o,
        output out_valid_o,
        input  out_ready_i,
        output out_result_o,
        output out_op_o,
        output out_zero_o,
        output out_neg_o
    );

    modport master (
        output in_valid_i,
        output in_result_i,
        output in_op_i,
        input  in_ready_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_result_o,
        input  out_op_o,
        input  out_zero_o,
        input  out_neg_o
    );
endinterface

// File: rtl/alu_result_stage.sv
// 2-entry in-order skid buffer for ALU/shifter results with zero/neg flags.
// Ports: clk_i, rst_i (sync, active-high), bus (slave), count_o, stall_cnt_o.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_result_stage_if.slave   bus,
    output logic [1:0]          count_o,
    output logic [15:0]         stall_cnt_o
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OPW-1:0]   op;
        logic             zero;
        logic             neg;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q;
    entry_t      head_q;
    entry_t      tail_q;
    entry_t      in_e;
    logic [15:0] stall_q;
    logic        push;
    logic        pop;
    logic        stalled;

    always_comb begin
        in_e        = '0;
        in_e.result = bus.in_result_i;
        in_e.op     = bus.in_op_i;
        in_e.zero   = (bus.in_result_i == '0);
        in_e.neg    = bus.in_result_i[WIDTH-1];
    end

    // Ready/valid derive from registered state only.
    assign bus.in_ready_o  = (state_q != FULL);
    assign bus.out_valid_o = (state_q != EMPTY);

    assign push    = bus.in_valid_i & bus.in_ready_o;
    assign pop     = bus.out_valid_o & bus.out_ready_i;
    assign stalled = bus.out_valid_o & ~bus.out_ready_i;

    // Head register is cleared whenever the stage empties,
    // so outputs read as zero while out_valid_o is low.
    assign bus.out_result_o = head_q.result;
    assign bus.out_op_o     = head_q.op;
    assign bus.out_zero_o   = head_q.zero;
    assign bus.out_neg_o    = head_q.neg;

    assign count_o     = state_q;
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            stall_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= in_e;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    unique case ({push, pop})
                        2'b10: begin
                            tail_q  <= in_e;
                            state_q <= FULL;
                        end
                        2'b01: begin
                            head_q  <= '0;
                            state_q <= EMPTY;
                        end
                        2'b11: begin
                            head_q <= in_e;
                        end
                        default: begin
                        end
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        tail_q  <= '0;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    head_q  <= '0;
                    tail_q  <= '0;
                end
            endcase

            // Saturating stall counter.
            if (stalled && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Drives the bus master side; checks 1 time unit after each rising edge.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  count;
    logic [15:0] stall_cnt;
    int          n_checks;
    int          n_errors;

    alu_result_stage_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_result_stage #(.WIDTH(32), .OPW(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .count_o     (count),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] res,
                        input logic [3:0] op, input logic z,
                        input logic n);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, "_res"}, bus.out_result_o, res);
        check({tag, "_op"}, 32'(bus.out_op_o), 32'(op));
        check({tag, "_zero"}, 32'(bus.out_zero_o), 32'(z));
        check({tag, "_neg"}, 32'(bus.out_neg_o), 32'(n));
    endtask

    task automatic idle(input string tag);
        check({tag, "_cnt"}, 32'(count), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_rdy"}, 32'(bus.in_ready_o), 32'd1);
        check({tag, "_res"}, bus.out_result_o, 32'd0);
        check({tag, "_op"}, 32'(bus.out_op_o), 32'd0);
        check({tag, "_flags"},
              32'({bus.out_zero_o, bus.out_neg_o}), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_result_i = '0;
        bus.in_op_i     = '0;
        bus.out_ready_i = 1'b0;
        tick();
        tick();
        idle("rst");
        check("rst_stall", 32'(stall_cnt), 32'd0);

        // Pass-through, pushed in first cycle after reset
        rst = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_result_i = 32'h0000_0001;
        bus.in_op_i     = 4'h3;
        bus.out_ready_i = 1'b1;
        tick();
        head("pt", 32'h1, 4'h3, 1'b0, 1'b0);
        check("pt_cnt", 32'(count), 32'd1);
        bus.in_valid_i = 1'b0;
        tick();
        idle("pt_drain");

        // Fill and stall
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_result_i = 32'h8000_0000;
        bus.in_op_i     = 4'h1;
        tick();
        check("fill1_cnt", 32'(count), 32'd1);
        head("fill1", 32'h8000_0000, 4'h1, 1'b0, 1'b1);
        check("fill1_stall", 32'(stall_cnt), 32'd0);
        bus.in_result_i = 32'h0000_0000;
        bus.in_op_i     = 4'h2;
        tick();
        check("fill2_cnt", 32'(count), 32'd2);
        check("fill2_rdy", 32'(bus.in_ready_o), 32'd0);
        head("fill2", 32'h8000_0000, 4'h1, 1'b0, 1'b1);
        check("fill2_stall", 32'(stall_cnt), 32'd1);
        bus.in_result_i = 32'h0000_0055;
        bus.in_op_i     = 4'h7;
        tick();
        check("full_cnt", 32'(count), 32'd2);
        head("full_hold", 32'h8000_0000, 4'h1, 1'b0, 1'b1);
        check("full_stall", 32'(stall_cnt), 32'd2);
        bus.in_valid_i = 1'b0;

        // Drain order
        bus.out_ready_i = 1'b1;
        tick();
        check("drain1_cnt", 32'(count), 32'd1);
        head("drain1", 32'h0, 4'h2, 1'b1, 1'b0);
        check("drain1_stall", 32'(stall_cnt), 32'd2);
        tick();
        idle("drain2");

        // Streaming 0..7
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_result_i = 32'(i);
            bus.in_op_i     = 4'(i + 8);
            tick();
            check("str_cnt", 32'(count), 32'd1);
            head("str", 32'(i), 4'(i + 8), (i == 0), 1'b0);
        end
        bus.in_valid_i = 1'b0;
        tick();
        idle("str_end");

        // Saturation
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_result_i = 32'h0000_000A;
        bus.in_op_i     = 4'h5;
        tick();
        bus.in_valid_i = 1'b0;
        check("sat_start", 32'(stall_cnt), 32'd2);
        repeat (70000) tick();
        check("sat_val", 32'(stall_cnt), 32'h0000_FFFF);
        head("sat_hold", 32'hA, 4'h5, 1'b0, 1'b0);
        tick();
        check("sat_nowrap", 32'(stall_cnt), 32'h0000_FFFF);

        // Mid-op reset from FULL
        bus.in_valid_i  = 1'b1;
        bus.in_result_i = 32'h0000_000B;
        bus.in_op_i     = 4'h6;
        tick();
        check("mid_full", 32'(count), 32'd2);
        rst = 1'b1;
        bus.out_ready_i = 1'b1;
        tick();
        idle("mid_rst");
        check("mid_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        tick();
        idle("mid_after");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
